// File: rtl/vc_pop_arbiter.sv
// Pop arbiter between NUM_VC first-word-fall-through VC FIFOs and NUM_DEST destination FIFOs.
// Strict-priority or weighted round-robin selection, with per-destination backpressure and a registered push stage.
module vc_pop_arbiter #(
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 2,
    parameter int DATA_W   = 6,
    parameter int DEST_LSB = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic                         mode,
    input  logic [NUM_VC-1:0]            vc_empty,
    input  logic [NUM_VC*DATA_W-1:0]     vc_data,
    input  logic [NUM_VC*WEIGHT_W-1:0]   vc_weight,
    input  logic [NUM_DEST-1:0]          dest_full,
    input  logic [NUM_DEST-1:0]          dest_almost_full,
    output logic [NUM_VC-1:0]            vc_pop,
    output logic [NUM_VC-1:0]            pop_delay,
    output logic [NUM_DEST-1:0]          dest_push,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_VC)-1:0]    grant_vc
);

    localparam int VC_W   = $clog2(NUM_VC);
    localparam int DEST_W = $clog2(NUM_DEST);
    localparam logic [DEST_W:0] DEST_LIMIT = (DEST_W + 1)'(NUM_DEST);

    logic [DEST_W-1:0]   dest_idx   [NUM_VC];
    logic [WEIGHT_W-1:0] eff_weight [NUM_VC];
    logic [NUM_DEST-1:0] paused;
    logic [NUM_VC-1:0]   elig;
    logic [NUM_DEST-1:0] push_next;

    logic [VC_W-1:0]     ptr;
    logic [WEIGHT_W-1:0] cnt;

    logic                grant_valid;
    logic                keep;
    logic [VC_W-1:0]     grant_idx;

    assign paused = dest_full | dest_almost_full;

    // A head word addressing a nonexistent destination is held back rather than dropped.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            dest_idx[i] = vc_data[i*DATA_W + DEST_LSB +: DEST_W];
            eff_weight[i] = (vc_weight[i*WEIGHT_W +: WEIGHT_W] == '0)
                          ? WEIGHT_W'(1) : vc_weight[i*WEIGHT_W +: WEIGHT_W];
            elig[i] = 1'b0;
            if (!vc_empty[i] && ({1'b0, dest_idx[i]} < DEST_LIMIT))
                elig[i] = ~paused[dest_idx[i]];
        end
    end

    always_comb begin
        logic [VC_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        keep        = 1'b0;
        cand        = '0;
        if (!mode) begin
            for (int i = NUM_VC - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = VC_W'(i);
                end
            end
        end else if (elig[ptr] && (cnt < eff_weight[ptr])) begin
            keep        = 1'b1;
            grant_valid = 1'b1;
            grant_idx   = ptr;
        end else begin
            // Scan farthest-first so the nearest eligible VC after ptr overwrites; ptr itself is tried last.
            for (int k = NUM_VC; k >= 1; k--) begin
                cand = VC_W'((int'(ptr) + k) % NUM_VC);
                if (elig[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        vc_pop = '0;
        if (reset_L && grant_valid)
            vc_pop[grant_idx] = 1'b1;
    end

    always_comb begin
        push_next = '0;
        if (grant_valid)
            push_next[dest_idx[grant_idx]] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_delay <= '0;
            dest_push <= '0;
            out_data  <= '0;
            grant_vc  <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            pop_delay <= vc_pop;
            dest_push <= push_next;
            if (grant_valid) begin
                out_data <= vc_data[grant_idx*DATA_W +: DATA_W];
                grant_vc <= grant_idx;
            end
            // Strict mode parks the WRR state so entering WRR always starts fresh at VC0.
            if (!mode) begin
                ptr <= '0;
                cnt <= '0;
            end else if (grant_valid) begin
                if (keep) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    ptr <= grant_idx;
                    cnt <= WEIGHT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
Parametrised pop arbiter that sits between NUM_VC virtual-channel FIFOs (first-word-fall-through heads) and NUM_DEST destination FIFOs.
- Each cycle it selects at most one VC to pop.
- Backpressure is per destination, taken from the head word's destination field. Only VCs whose own target is paused are stalled; the other VCs keep flowing.
- Two arbitration modes: strict priority and weighted round-robin (WRR).
- The popped word and a one-hot destination push are registered one cycle after the pop.

Parameters:
NUM_VC, 2, number of source virtual channels (>=2).
NUM_DEST, 2, number of destination FIFOs (>=2).
DATA_W, 6, word width.
DEST_LSB, 4, LSB of the destination field in a word. Field width DEST_W = clog2(NUM_DEST).
WEIGHT_W, 4, width of each WRR weight.

Ports:
clk  in  1  clock; all state on rising edge.
reset_L  in  1  asynchronous, active-low reset.
mode  in  1  0 = strict priority (lowest index wins), 1 = WRR.
vc_empty  in  NUM_VC  per-VC FIFO empty.
vc_data  in  NUM_VC*DATA_W  per-VC head words; VC i occupies bits [i*DATA_W +: DATA_W].
vc_weight  in  NUM_VC*WEIGHT_W  per-VC WRR weight; 0 is treated as 1.
dest_full  in  NUM_DEST  destination FIFO full.
dest_almost_full  in  NUM_DEST  destination FIFO almost full.
vc_pop  out  NUM_VC  combinational pop strobe, at most one bit high.
pop_delay  out  NUM_VC  registered copy of vc_pop.
dest_push  out  NUM_DEST  registered one-hot push to destination.
out_data  out  DATA_W  registered popped word.
grant_vc  out  clog2(NUM_VC)  registered index of the last granted VC.

Behaviour:
Reset (reset_L low, asynchronous):
- pop_delay=0, dest_push=0, out_data=0, grant_vc=0, ptr=0, cnt=0.
- vc_pop is forced to 0 combinationally while reset_L is low.
- Reset mid-operation discards any in-flight word: no push in the cycle after reset deasserts.

Eligibility and destination:
- dest(i) = vc_data[i][DEST_LSB +: DEST_W].
- paused(d) = dest_full[d] | dest_almost_full[d].
- eligible(i) = ~vc_empty[i] & ~paused(dest(i)).
- A destination index >= NUM_DEST is ineligible. That VC stalls, because such a word must never be dropped.

Mode 0 (strict priority):
- vc_pop = one-hot of the lowest-index eligible VC.
- Each clock sets ptr=0, cnt=0.

Mode 1 (WRR). State is ptr (current VC) and cnt (grants already given to ptr, WEIGHT_W bits).
- Keep case: if eligible(ptr) and cnt < weight(ptr), grant ptr. Next clock: cnt <= cnt+1.
- Rotate case: otherwise, grant the first eligible VC scanning ptr+1, ptr+2, … with wrap, ptr itself last. Next clock: ptr <= granted, cnt <= 1.
- No eligible VC: no grant; ptr and cnt hold.
- Changing mode takes effect the same cycle. Entering WRR starts from ptr=0, cnt=0.

Registered stage (latency 1 from vc_pop):
- pop_delay <= vc_pop.
- On a grant to VC g:
  - dest_push <= one-hot(dest(g)).
  - out_data <= vc_data[g].
  - grant_vc <= g.
- No grant: dest_push <= 0; out_data and grant_vc hold.

Backpressure and combinational paths:
- almost_full covers the one in-flight push. The bench guarantees each destination FIFO asserts almost_full with at least one free slot.
- Simultaneous full and almost_full on a destination behaves the same as either alone.
- No combinational path from dest_push or out_data back to vc_pop. vc_pop depends only on the inputs, ptr, cnt and mode.

Test Plan:
- Reset: reset_L=0 with all VCs non-empty -> vc_pop=0, dest_push=0, out_data=0. Deassert reset_L -> first pop in the same cycle, first push one cycle later.
- Strict mode, NUM_VC=2: both VCs non-empty, VC0 head dest 0, VC1 head dest 1 -> vc_pop=01 every cycle. Set vc_empty[0]=1 -> vc_pop=10, dest_push=10 one cycle later, out_data = VC1 head.
- Per-destination pause: dest_almost_full=01, VC0 head dest 0, VC1 head dest 1 -> VC0 stalls, vc_pop=10. Clear the pause -> vc_pop=01 next evaluation.
- WRR with weights VC0=3, VC1=1, both always eligible -> repeating grant sequence 0,0,0,1 and grant_vc follows it one cycle late. Weight 0 on VC1 -> sequence 0,0,0,1, identical to weight 1.
- WRR wrap, NUM_VC=4, weights all 1, VC2 empty -> grant order 0,1,3,0,1,3. Make VC2 eligible while ptr=1 -> next grant is 2.
- Async reset asserted mid-burst between clock edges -> outputs go to 0 immediately. After release, WRR restarts at VC0 and no stale push occurs.
